// File: rtl/corelet_ctrl.sv
// Tile sequencer for the corelet datapath and its xmem/psum SRAMs.
// Define CORELET_CTRL_PERF_EN to add the o_perf_cycles busy-cycle counter.
module corelet_ctrl #(
   parameter int row = 8,
   parameter int col = 8,
   parameter int nij = 16,
   parameter int xaw = 11,
   parameter int paw = 11
) (
   input  logic           i_clk,
   input  logic           i_reset,
   input  logic           i_start,
   output logic           o_xmem_cen,
   output logic [xaw-1:0] o_xmem_addr,
   output logic           o_l0_wr,
   output logic           o_l0_rd,
   input  logic           i_l0_full,
   output logic [1:0]     o_inst_w,
   input  logic           i_ofifo_valid,
   output logic           o_ofifo_rd,
   output logic           o_pmem_cen,
   output logic           o_pmem_wen,
   output logic [paw-1:0] o_pmem_addr,
   output logic           o_sfu_acc_en,
   output logic           o_sfu_write_en,
   output logic           o_busy,
   output logic           o_done
`ifdef CORELET_CTRL_PERF_EN
   ,
   output logic [31:0]    o_perf_cycles
`endif
);

   localparam logic [3:0] S_IDLE  = 4'd0;
   localparam logic [3:0] S_KLOAD = 4'd1;
   localparam logic [3:0] S_KFEED = 4'd2;
   localparam logic [3:0] S_KWAIT = 4'd3;
   localparam logic [3:0] S_ALOAD = 4'd4;
   localparam logic [3:0] S_EXEC  = 4'd5;
   localparam logic [3:0] S_DRAIN = 4'd6;
   localparam logic [3:0] S_ACC   = 4'd7;
   localparam logic [3:0] S_SWR   = 4'd8;
   localparam logic [3:0] S_DONE  = 4'd9;

   localparam int CW = 16;
   localparam logic [CW-1:0] C_COL  = CW'(col);
   localparam logic [CW-1:0] C_NIJ  = CW'(nij);
   localparam logic [CW-1:0] C_XEND = CW'(col + nij);
   localparam logic [CW-1:0] C_WAIT = CW'((row > 1) ? row - 2 : 0);
   localparam logic [3:0]    S_AFTER_KFEED = (row > 1) ? S_KWAIT : S_ALOAD;

   logic [3:0]    r_state;
   logic [3:0]    w_state_next;
   logic          r_l0_wr;
   logic          r_acc_en;
   logic [CW-1:0] r_xaddr;
   logic [CW-1:0] r_lcnt;
   logic [CW-1:0] r_cyc;
   logic [CW-1:0] r_wcnt;
   logic [CW-1:0] r_acnt;
   logic [CW-1:0] r_scnt;

   logic          w_start;
   logic          w_in_load;
   logic [CW-1:0] w_xlimit;
   logic [CW-1:0] w_llimit;
   logic          w_x_issue;
   logic          w_ld_last;
   logic          w_drain;
   logic          w_p_rd;
   logic          w_acc_last;
   logic          w_cyc_last;
   logic          w_cyc_run;

   assign w_start   = (r_state == S_IDLE) && i_start;
   assign w_in_load = (r_state == S_KLOAD) || (r_state == S_ALOAD);
   assign w_xlimit  = (r_state == S_KLOAD) ? C_COL : C_XEND;
   assign w_llimit  = (r_state == S_KLOAD) ? C_COL : C_NIJ;
   // r_l0_wr doubles as the in-flight flag: at most one SRAM read outstanding.
   assign w_x_issue = w_in_load && !i_l0_full && !r_l0_wr && (r_xaddr < w_xlimit);
   assign w_ld_last = w_in_load && r_l0_wr && (r_lcnt == w_llimit - 1'b1);
   assign w_drain   = ((r_state == S_EXEC) || (r_state == S_DRAIN)) &&
                      i_ofifo_valid && (r_wcnt < C_NIJ);
   assign w_p_rd    = (r_state == S_ACC) && (r_acnt < C_NIJ);
   assign w_acc_last = r_acc_en && (r_scnt == C_NIJ - 1'b1);
   assign w_cyc_run = (r_state == S_KFEED) || (r_state == S_KWAIT) || (r_state == S_EXEC);

   always_comb begin
      w_cyc_last = 1'b0;
      case (r_state)
         S_KFEED: w_cyc_last = (r_cyc == C_COL - 1'b1);
         S_KWAIT: w_cyc_last = (r_cyc == C_WAIT);
         S_EXEC:  w_cyc_last = (r_cyc == C_NIJ - 1'b1);
         default: w_cyc_last = 1'b0;
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start)     w_state_next = S_KLOAD;
         S_KLOAD: if (w_ld_last)   w_state_next = S_KFEED;
         S_KFEED: if (w_cyc_last)  w_state_next = S_AFTER_KFEED;
         S_KWAIT: if (w_cyc_last)  w_state_next = S_ALOAD;
         S_ALOAD: if (w_ld_last)   w_state_next = S_EXEC;
         S_EXEC:  if (w_cyc_last)  w_state_next = S_DRAIN;
         S_DRAIN: if (r_wcnt == C_NIJ) w_state_next = S_ACC;
         S_ACC:   if (w_acc_last)  w_state_next = S_SWR;
         S_SWR:   w_state_next = S_DONE;
         S_DONE:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_l0_wr  <= 1'b0;
         r_acc_en <= 1'b0;
         r_xaddr  <= '0;
         r_lcnt   <= '0;
         r_cyc    <= '0;
         r_wcnt   <= '0;
         r_acnt   <= '0;
         r_scnt   <= '0;
      end else begin
         r_state  <= w_state_next;
         r_l0_wr  <= w_x_issue;
         r_acc_en <= w_p_rd;
         if (w_start) begin
            r_xaddr <= '0;
            r_lcnt  <= '0;
            r_cyc   <= '0;
            r_wcnt  <= '0;
            r_acnt  <= '0;
            r_scnt  <= '0;
         end else begin
            // xaddr runs on from KLOAD into ALOAD, so it is never cleared mid-tile.
            if (w_x_issue) r_xaddr <= r_xaddr + 1'b1;
            if (w_ld_last)    r_lcnt <= '0;
            else if (r_l0_wr) r_lcnt <= r_lcnt + 1'b1;
            if (w_state_next != r_state) r_cyc <= '0;
            else if (w_cyc_run)          r_cyc <= r_cyc + 1'b1;
            if (w_drain) r_wcnt <= r_wcnt + 1'b1;
            if (w_p_rd)  r_acnt <= r_acnt + 1'b1;
            if (r_acc_en && (r_scnt < C_NIJ)) r_scnt <= r_scnt + 1'b1;
         end
      end
   end

   assign o_xmem_cen     = !w_x_issue;
   assign o_xmem_addr    = w_x_issue ? xaw'(r_xaddr) : '0;
   assign o_l0_wr        = r_l0_wr;
   assign o_l0_rd        = (r_state == S_KFEED) || (r_state == S_EXEC);
   assign o_inst_w       = {(r_state == S_EXEC), (r_state == S_KFEED)};
   assign o_ofifo_rd     = w_drain;
   assign o_pmem_cen     = !(w_drain || w_p_rd);
   assign o_pmem_wen     = !w_drain;
   assign o_pmem_addr    = w_drain ? paw'(r_wcnt) : (w_p_rd ? paw'(r_acnt) : '0);
   assign o_sfu_acc_en   = r_acc_en;
   assign o_sfu_write_en = (r_state == S_SWR);
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = (r_state == S_DONE);

`ifdef CORELET_CTRL_PERF_EN
   logic [31:0] r_perf_cycles;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_perf_cycles <= '0;
      end else if (w_start) begin
         r_perf_cycles <= '0;
      end else if ((r_state != S_IDLE) && (r_perf_cycles != 32'hFFFF_FFFF)) begin
         r_perf_cycles <= r_perf_cycles + 1'b1;
      end
   end

   assign o_perf_cycles = r_perf_cycles;
`endif

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: expected addresses queued at tile start,
// a negedge monitor pops and compares whenever the DUT presents an SRAM access.
module tb_corelet_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        l0_full = 1'b0;
   logic        ofifo_valid = 1'b0;
   logic        xmem_cen, l0_wr, l0_rd, ofifo_rd, pmem_cen, pmem_wen;
   logic        sfu_acc_en, sfu_write_en, busy, done;
   logic [10:0] xmem_addr, pmem_addr;
   logic [1:0]  inst_w;
`ifdef CORELET_CTRL_PERF_EN
   logic [31:0] perf;
`endif

   corelet_ctrl dut (
      .i_clk(clk), .i_reset(reset), .i_start(start),
      .o_xmem_cen(xmem_cen), .o_xmem_addr(xmem_addr),
      .o_l0_wr(l0_wr), .o_l0_rd(l0_rd), .i_l0_full(l0_full),
      .o_inst_w(inst_w), .i_ofifo_valid(ofifo_valid), .o_ofifo_rd(ofifo_rd),
      .o_pmem_cen(pmem_cen), .o_pmem_wen(pmem_wen), .o_pmem_addr(pmem_addr),
      .o_sfu_acc_en(sfu_acc_en), .o_sfu_write_en(sfu_write_en),
      .o_busy(busy), .o_done(done)
`ifdef CORELET_CTRL_PERF_EN
      , .o_perf_cycles(perf)
`endif
   );

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int xq[$];
   int pwq[$];
   int prq[$];
   bit mon_en = 1'b0;
   bit stray = 1'b0;
   int cyc = 0, last01 = 0;
   int busy_cnt, l0wr_cnt, i01_cnt, i10_cnt, acc_cnt, swr_cnt, done_cnt;
   bit prev_cen = 1'b1, prev_prd = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end else begin
         $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
      end
   endtask

   task automatic pop_chk(input string name, inout int q[$], input int act);
      if (q.size() == 0) chk({name, "_underflow"}, 1, 0);
      else chk(name, act, q.pop_front());
   endtask

   // OFIFO model: a row is ready in each EXEC cycle, plus optional stray pulses.
   initial forever begin
      @(posedge clk);
      #1 ofifo_valid = (inst_w == 2'b10) || stray;
   end

   always @(negedge clk) begin
      cyc++;
      if (mon_en) begin
         if (busy) busy_cnt++;
         if (!xmem_cen) begin
            pop_chk("xmem_addr", xq, int'(xmem_addr));
            chk("xrd_spacing", prev_cen, 1);
            if (xmem_addr == 11'd8) chk("kwait_gap", cyc - last01, 8);
         end
         if (l0_full) chk("stall_cen", xmem_cen, 1);
         if (l0_wr) begin
            l0wr_cnt++;
            if (l0_rd) chk("l0_rd_wr_overlap", 1, 0);
         end
         if (inst_w == 2'b01) begin i01_cnt++; last01 = cyc; end
         if (inst_w == 2'b10) i10_cnt++;
         if (!pmem_cen && !pmem_wen) begin
            pop_chk("pmem_waddr", pwq, int'(pmem_addr));
            chk("ofifo_rd_with_wr", ofifo_rd, 1);
         end else if (ofifo_rd) begin
            chk("ofifo_rd_stray", ofifo_rd, 0);
         end
         if (!pmem_cen && pmem_wen) pop_chk("pmem_raddr", prq, int'(pmem_addr));
         if (sfu_acc_en) begin
            acc_cnt++;
            chk("acc_after_read", prev_prd, 1);
         end
         if (sfu_write_en) swr_cnt++;
         if (done) done_cnt++;
      end
      prev_cen = xmem_cen;
      prev_prd = !pmem_cen && pmem_wen;
   end

   task automatic run_tile(input bit stall, input bit poke);
      int c;
      busy_cnt = 0; l0wr_cnt = 0; i01_cnt = 0; i10_cnt = 0;
      acc_cnt = 0; swr_cnt = 0; done_cnt = 0;
      xq.delete(); pwq.delete(); prq.delete();
      for (int i = 0; i < 24; i++) xq.push_back(i);
      for (int i = 0; i < 16; i++) begin pwq.push_back(i); prq.push_back(i); end
      mon_en = 1'b1;
      for (c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         start   = (c == 0) || (poke && (c == 40));
         l0_full = stall && (c >= 3) && (c < 8);
         if (done_cnt > 0) break;
      end
      start = 1'b0;
      l0_full = 1'b0;
      if (c == 400) chk("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_pulses", done_cnt, 1);
      chk("l0_wr_total", l0wr_cnt, 24);
      chk("kfeed_cycles", i01_cnt, 8);
      chk("exec_cycles", i10_cnt, 16);
      chk("sfu_acc_strobes", acc_cnt, 16);
      chk("sfu_write_strobes", swr_cnt, 1);
      chk("xq_left", xq.size(), 0);
      chk("pwq_left", pwq.size(), 0);
      chk("prq_left", prq.size(), 0);
      chk("idle_busy", busy, 0);
      if (!stall) chk("busy_cycles", busy_cnt, 99);
`ifdef CORELET_CTRL_PERF_EN
      chk("perf_vs_busy", perf, busy_cnt);
      if (!stall) chk("perf_cycles", perf, 99);
`endif
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_xmem_cen", xmem_cen, 1);
      chk("rst_pmem_cen", pmem_cen, 1);
      chk("rst_pmem_wen", pmem_wen, 1);
      chk("rst_inst_w", inst_w, 0);
      chk("rst_l0_wr", l0_wr, 0);
      chk("rst_done", done, 0);
      chk("rst_xmem_addr", xmem_addr, 0);
      chk("rst_pmem_addr", pmem_addr, 0);
`ifdef CORELET_CTRL_PERF_EN
      chk("rst_perf", perf, 0);
`endif
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      run_tile(1'b0, 1'b0);
      run_tile(1'b1, 1'b1);

      // ofifo_valid while idle must not pop or write
      stray = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #2;
         chk("idle_ofifo_rd", ofifo_rd, 0);
         chk("idle_pmem_cen", pmem_cen, 1);
      end
      stray = 1'b0;
      @(posedge clk);

      // abort mid-EXEC with asynchronous reset
      mon_en = 1'b0;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      begin
         int k;
         for (k = 0; k < 200 && inst_w != 2'b10; k++) @(posedge clk);
         if (k == 200) chk("exec_timeout", 0, 1);
      end
      repeat (4) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_inst_w", inst_w, 0);
      chk("abort_xmem_cen", xmem_cen, 1);
      chk("abort_pmem_cen", pmem_cen, 1);
      chk("abort_pmem_wen", pmem_wen, 1);
      chk("abort_l0_rd", l0_rd, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      run_tile(1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
